// File: rtl/head_table_lookup.sv
// rtl/head_table_lookup.sv - key hash, head-pointer RAM read and credit-controlled task FIFO (optional HEAD_LOOKUP_STATS_EN stats)

localparam int HT_KEY_WIDTH        = 16;
localparam int HT_VALUE_WIDTH      = 16;
localparam int HT_OP_WIDTH         = 2;
localparam int HT_TABLE_ADDR_WIDTH = 10;
localparam int HT_BUCKET_WIDTH     = 8;

typedef struct packed {
  logic [HT_KEY_WIDTH-1:0]   key;
  logic [HT_VALUE_WIDTH-1:0] value;
  logic [HT_OP_WIDTH-1:0]    opcode;
} ht_command_t;

typedef struct packed {
  ht_command_t                    cmd;
  logic [HT_BUCKET_WIDTH-1:0]     bucket;
  logic [HT_TABLE_ADDR_WIDTH-1:0] head_ptr;
  logic                           head_ptr_val;
} ht_pdata_t;

module head_table_lookup #(
  parameter int A_WIDTH    = HT_TABLE_ADDR_WIDTH,
  parameter int B_WIDTH    = HT_BUCKET_WIDTH,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  ht_command_t        cmd_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  output logic [B_WIDTH-1:0] head_rd_addr_o,
  output logic               head_rd_en_o,
  input  logic [A_WIDTH-1:0] head_rd_ptr_i,
  input  logic               head_rd_ptr_val_i,
  output ht_pdata_t          task_o,
  output logic               task_valid_o,
  input  logic               task_ready_i
`ifdef HEAD_LOOKUP_STATS_EN
  ,
  output logic [31:0]                   stat_cmd_cnt_o,
  output logic [31:0]                   stat_empty_bucket_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   stat_max_occ_o
`endif
);

  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int N_SLICES  = (HT_KEY_WIDTH + B_WIDTH - 1) / B_WIDTH;
  localparam int PAD_WIDTH = N_SLICES * B_WIDTH;

  logic [PAD_WIDTH-1:0] key_pad;
  logic [B_WIDTH-1:0]   bucket;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        fifo_cnt;
  logic [CW-1:0]        occupancy;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;

  logic [RD_LATENCY-1:0] pipe_vld;
  ht_command_t           pipe_cmd [RD_LATENCY];
  logic [B_WIDTH-1:0]    pipe_bkt [RD_LATENCY];
  ht_pdata_t             push_data;
  ht_pdata_t             fifo_mem [FIFO_DEPTH];

  // Bucket hash: XOR-fold the zero-padded key in B_WIDTH slices.
  always_comb begin
    key_pad = '0;
    key_pad[HT_KEY_WIDTH-1:0] = cmd_i.key;
    bucket = '0;
    for (int s = 0; s < N_SLICES; s++) begin
      bucket = bucket ^ key_pad[s*B_WIDTH +: B_WIDTH];
    end
  end

  // Credits cover both reads in flight and FIFO entries, so a granted
  // command always has a FIFO slot waiting when its RAM data returns.
  assign occupancy      = inflight + fifo_cnt;
  assign cmd_ready_o    = rst_i && (occupancy < CW'(FIFO_DEPTH));
  assign accept         = cmd_valid_i && cmd_ready_o;
  assign head_rd_en_o   = accept;
  assign head_rd_addr_o = bucket;

  assign push         = pipe_vld[RD_LATENCY-1];
  assign task_valid_o = (fifo_cnt != '0);
  assign pop          = task_valid_o && task_ready_i;
  assign task_o       = task_valid_o ? fifo_mem[rd_ptr] : '0;

  // Valid bits of the read-latency pipe; cleared on reset so late RAM data is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Command and bucket ride alongside the RAM read; no reset needed on data.
  always_ff @(posedge clk_i) begin
    pipe_cmd[0] <= cmd_i;
    pipe_bkt[0] <= bucket;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_cmd[i] <= pipe_cmd[i-1];
      pipe_bkt[i] <= pipe_bkt[i-1];
    end
  end

  // Join the pipe output with the RAM data returned in the same cycle.
  always_comb begin
    push_data              = '0;
    push_data.cmd          = pipe_cmd[RD_LATENCY-1];
    push_data.bucket       = pipe_bkt[RD_LATENCY-1];
    push_data.head_ptr     = head_rd_ptr_i;
    push_data.head_ptr_val = head_rd_ptr_val_i;
  end

  // FIFO storage write port.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, occupancy and in-flight read counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      inflight <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Credit accounting must make a push into a full FIFO unreachable.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    push |-> (fifo_cnt != CW'(FIFO_DEPTH)));

`ifdef HEAD_LOOKUP_STATS_EN
  logic [31:0]   cmd_cnt;
  logic [31:0]   empty_cnt;
  logic [CW-1:0] max_occ;

  // Statistics: accepted commands, empty-bucket lookups, FIFO high-water mark.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cmd_cnt   <= '0;
      empty_cnt <= '0;
      max_occ   <= '0;
    end else begin
      if (accept) cmd_cnt <= cmd_cnt + 32'd1;
      if (push && !head_rd_ptr_val_i) empty_cnt <= empty_cnt + 32'd1;
      if (fifo_cnt > max_occ) max_occ <= fifo_cnt;
    end
  end

  assign stat_cmd_cnt_o          = cmd_cnt;
  assign stat_empty_bucket_cnt_o = empty_cnt;
  assign stat_max_occ_o          = max_occ;
`endif

endmodule
